// File: rtl/lutk_array_pkg.sv
// Shared types and size helpers for the K-input LUT array.
package lutk_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_e;

  localparam int unsigned MIN_K = 2;
  localparam int unsigned MAX_K = 6;

  // Truth-table width of one K-input LUT.
  function automatic int unsigned tt_bits(input int unsigned k);
    return 32'd1 << k;
  endfunction

  // Chain slice owned by one LUT: truth table plus the REG mode bit.
  function automatic int unsigned slice_bits(input int unsigned k);
    return tt_bits(k) + 32'd1;
  endfunction

  // Total configuration chain length.
  function automatic int unsigned cfg_bits(input int unsigned k, input int unsigned n);
    return n * slice_bits(k);
  endfunction

endpackage

// File: rtl/lutk_array_cell.sv
// One K-input LUT: truth-table mux plus optional output register.
module lutk_cell
  import lutk_array_pkg::*;
#(
  parameter int unsigned K = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  clear_i,
  input  logic                  active_i,
  input  logic                  reg_i,
  input  logic [tt_bits(K)-1:0] tt_i,
  input  logic [K-1:0]          lut_in_i,
  output logic                  lut_o
);

  logic f_c;
  logic flop_d;
  logic flop_q;

  assign f_c = tt_i[lut_in_i];

  // Flop follows the LUT function only while active; a new load clears it.
  always_comb begin
    flop_d = 1'b0;
    if (!clear_i && active_i) begin
      flop_d = f_c;
    end
  end

  // Output register, frozen while the design is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      flop_q <= 1'b0;
    end else if (ena) begin
      flop_q <= flop_d;
    end
  end

  // Pins stay low outside ACTIVE so partial tables never reach them.
  assign lut_o = active_i & (reg_i ? flop_q : f_c);

endmodule

// File: rtl/lutk_array.sv
// Array of NUM_LUTS K-input LUTs configured through a serial shift chain.
module lutk_array
  import lutk_array_pkg::*;
#(
  parameter int unsigned K        = 4,
  parameter int unsigned NUM_LUTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  cfg_load,
  input  logic                  cfg_valid,
  input  logic                  cfg_data,
  output logic                  cfg_out,
  output logic                  cfg_done,
  input  logic [NUM_LUTS*K-1:0] lut_in,
  output logic [NUM_LUTS-1:0]   lut_out
);

  localparam int unsigned TT_BITS  = tt_bits(K);
  localparam int unsigned SLICE    = slice_bits(K);
  localparam int unsigned CFG_BITS = cfg_bits(K, NUM_LUTS);
  localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);

  state_e              state_q;
  logic [CFG_BITS-1:0] chain_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                done_q;
  logic                active_c;

  // Load FSM, bit counter and configuration chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chain_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (ena) begin
      case (state_q)
        ST_LOADING: begin
          if (cfg_load) begin
            // Restart keeps the chain; only the count starts over.
            cnt_q <= '0;
          end else if (cfg_valid) begin
            chain_q <= {chain_q[CFG_BITS-2:0], cfg_data};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
              state_q <= ST_ACTIVE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          if (cfg_load) begin
            state_q <= ST_LOADING;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign active_c = (state_q == ST_ACTIVE);
  assign cfg_done = done_q;
  assign cfg_out  = chain_q[CFG_BITS-1];

  // One cell per LUT, each reading its own slice of the chain.
  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_cell
    lutk_cell #(
      .K(K)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .clear_i (cfg_load),
      .active_i(active_c),
      .reg_i   (chain_q[i*SLICE + TT_BITS]),
      .tt_i    (chain_q[i*SLICE +: TT_BITS]),
      .lut_in_i(lut_in[i*K +: K]),
      .lut_o   (lut_out[i])
    );
  end

endmodule
